// File: rtl/mem_arbiter.sv
// Byte-wide memory port arbiter: serialises fetch and load/store requests into
// per-byte bus cycles and assembles little-endian read data.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              flush,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              lsb_en,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_len,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [DATA_W-1:0] lsb_wdata,
    output logic              lsb_done,
    output logic [DATA_W-1:0] lsb_rdata
);

    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

    state_t            state, state_nxt;
    logic              last_ls, owner_ls, wr_q;
    logic [2:0]        idx, n_q, ls_n, idx_p1, idx_m1;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              grant_if, grant_ls, io_stall, reading;

    always_comb begin
        ls_n     = (lsb_len == 2'd0) ? 3'd1 : (lsb_len == 2'd1) ? 3'd2 : 3'd4;
        grant_if = if_en && !flush && (!lsb_en || last_ls);
        grant_ls = lsb_en && !flush && (!if_en || !last_ls);
        io_stall = (mem_a[17:16] == 2'b11) && io_buffer_full;
        reading  = (state == IF_RD) || (state == LS_RD);
        idx_p1   = 3'(idx + 3'd1);
        idx_m1   = 3'(idx - 3'd1);
        mem_wr    = wr_q && rdy && !io_stall;
        if_done   = (state == DONE) && !owner_ls;
        lsb_done  = (state == DONE) && owner_ls;
        if_data   = rdata_q;
        lsb_rdata = rdata_q;
        state_nxt = state;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (grant_if)      state_nxt = IF_RD;
                    else if (grant_ls) state_nxt = lsb_wr ? LS_WR : LS_RD;
                end
                IF_RD, LS_RD: begin
                    if (flush)             state_nxt = IDLE;
                    else if (idx == n_q)   state_nxt = DONE;
                end
                LS_WR: if (!io_stall && idx_p1 == n_q) state_nxt = DONE;
                DONE:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ls  <= 1'b1;
            owner_ls <= 1'b0;
            wr_q     <= 1'b0;
            idx      <= '0;
            n_q      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
        end else if (!rdy) begin
            // Reads rewind while frozen so the byte pipeline restarts cleanly from byte 0.
            if (reading) begin
                idx     <= '0;
                rdata_q <= '0;
                mem_a   <= addr_q;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if || grant_ls) begin
                        owner_ls <= grant_ls;
                        last_ls  <= grant_ls;
                        addr_q   <= grant_ls ? lsb_addr : if_pc;
                        mem_a    <= grant_ls ? lsb_addr : if_pc;
                        n_q      <= grant_ls ? ls_n : 3'd4;
                        wdata_q  <= lsb_wdata;
                        idx      <= '0;
                        rdata_q  <= '0;
                        if (grant_ls && lsb_wr) begin
                            mem_dout <= lsb_wdata[7:0];
                            wr_q     <= 1'b1;
                        end
                    end
                end
                IF_RD, LS_RD: begin
                    if (!flush) begin
                        // mem_din carries the byte addressed two edges ago
                        if (idx != 3'd0) rdata_q[{idx_m1[1:0], 3'b000} +: 8] <= mem_din;
                        idx <= idx_p1;
                        if (idx_p1 < n_q) mem_a <= addr_q + ADDR_W'(idx_p1);
                    end
                end
                LS_WR: begin
                    if (!io_stall) begin
                        if (idx_p1 == n_q) begin
                            wr_q <= 1'b0;
                        end else begin
                            idx      <= idx_p1;
                            mem_a    <= addr_q + ADDR_W'(idx_p1);
                            mem_dout <= wdata_q[{idx_p1[1:0], 3'b000} +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
    logic [7:0]  mem_din = 8'h00, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full = 1'b0, flush = 1'b0;
    logic        if_en = 1'b0, if_done;
    logic [31:0] if_pc = '0, if_data;
    logic        lsb_en = 1'b0, lsb_wr = 1'b0, lsb_done;
    logic [1:0]  lsb_len = 2'd0;
    logic [31:0] lsb_addr = '0, lsb_wdata = '0, lsb_rdata;

    logic [7:0]  ram [0:262143];
    logic        loaded = 1'b0;
    int          wr_count = 0;
    int          total = 0, bad = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .flush(flush),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
            ram[18'h00100] <= 8'h13; ram[18'h00101] <= 8'h05;
            ram[18'h00102] <= 8'h00; ram[18'h00103] <= 8'h00;
            ram[18'h00200] <= 8'h93; ram[18'h00201] <= 8'h00;
            ram[18'h00202] <= 8'h10; ram[18'h00203] <= 8'h00;
            ram[18'h00300] <= 8'h78; ram[18'h00301] <= 8'h56;
            ram[18'h00302] <= 8'h34; ram[18'h00303] <= 8'h12;
            ram[18'h02004] <= 8'h77;
            ram[18'h3FFFE] <= 8'hAA; ram[18'h3FFFF] <= 8'hBB;
            ram[18'h00000] <= 8'h11; ram[18'h00001] <= 8'h22;
            loaded <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wr_count <= wr_count + 1;
        end
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue_if(input logic [31:0] pc);
        if_pc = pc;
        if_en = 1'b1;
    endtask

    task automatic issue_ls(input logic wr, input logic [1:0] len, input logic [31:0] a,
                            input logic [31:0] d);
        lsb_wr    = wr;
        lsb_len   = len;
        lsb_addr  = a;
        lsb_wdata = d;
        lsb_en    = 1'b1;
    endtask

    task automatic wait_done(input bit ls, output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if ((ls ? lsb_done : if_done) == 1'b1) begin
                lat = k;
                break;
            end
        end
        chk(ls ? "lsb_done_seen" : "if_done_seen", 32'(ls ? lsb_done : if_done), 32'd1);
        if (ls) lsb_en = 1'b0;
        else    if_en  = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
    } load_vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int        lat, wc, n, first_lat;
        logic      order [0:3];
        logic [31:0] dat [0:3];
        logic      seen;
        load_vec_t lv [0:3];

        lv[0] = '{2'd0, 32'h0000_0303, 32'h0000_0012, 3};
        lv[1] = '{2'd1, 32'h0000_0300, 32'h0000_5678, 4};
        lv[2] = '{2'd2, 32'h0000_0300, 32'h1234_5678, 6};
        lv[3] = '{2'd3, 32'hFFFF_FFFE, 32'h2211_BBAA, 6};

        repeat (3) @(negedge clk);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_lsb_done", 32'(lsb_done), 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        rst = 1'b1;

        // word fetch
        @(negedge clk); issue_if(32'h100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fetch_addr", mem_a, 32'h100 + 32'(k));
            chk("fetch_wr", 32'(mem_wr), 32'h0);
        end
        wait_done(1'b0, lat);
        chk("fetch_lat", 32'(lat + 4), 32'd6);
        chk("fetch_data", if_data, 32'h0000_0513);
        @(negedge clk);
        chk("fetch_pulse_len", 32'(if_done), 32'h0);

        // half store
        wc = wr_count;
        issue_ls(1'b1, 2'd1, 32'h2002, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sh_a0", mem_a, 32'h2002); chk("sh_d0", 32'(mem_dout), 32'hEF); chk("sh_w0", 32'(mem_wr), 32'h1);
        @(negedge clk);
        chk("sh_a1", mem_a, 32'h2003); chk("sh_d1", 32'(mem_dout), 32'hBE); chk("sh_w1", 32'(mem_wr), 32'h1);
        wait_done(1'b1, lat);
        chk("sh_lat", 32'(lat + 2), 32'd3);
        chk("sh_ram0", 32'(ram[18'h2002]), 32'hEF);
        chk("sh_ram1", 32'(ram[18'h2003]), 32'hBE);
        chk("sh_ram2", 32'(ram[18'h2004]), 32'h77);
        chk("sh_wcount", 32'(wr_count - wc), 32'd2);

        // loads of each length, including address wrap
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); issue_ls(1'b0, lv[i].len, lv[i].addr, 32'h0);
            wait_done(1'b1, lat);
            chk("ld_lat", 32'(lat), 32'(lv[i].lat));
            chk("ld_data", lsb_rdata, lv[i].data);
        end

        // contention from reset
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        issue_if(32'h100);
        issue_ls(1'b0, 2'd3, 32'h300, 32'h0);
        n = 0; first_lat = 0;
        for (int k = 1; k <= 60 && n < 4; k++) begin
            @(negedge clk);
            if (if_done || lsb_done) begin
                if (n == 0) first_lat = k;
                order[n] = lsb_done;
                dat[n]   = lsb_done ? lsb_rdata : if_data;
                n++;
            end
        end
        if_en = 1'b0; lsb_en = 1'b0;
        chk("arb_count", 32'(n), 32'd4);
        chk("arb_first_lat", 32'(first_lat), 32'd6);
        for (int i = 0; i < 4 && i < n; i++) begin
            chk("arb_order", 32'(order[i]), 32'(i % 2));
            chk("arb_data", dat[i], (i % 2 == 1) ? 32'h1234_5678 : 32'h0000_0513);
        end

        // flush during fetch
        @(negedge clk); issue_if(32'h200);
        @(negedge clk);
        @(negedge clk); flush = 1'b1; if_en = 1'b0;
        @(negedge clk); flush = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | if_done | lsb_done | mem_wr;
        end
        chk("flush_if_quiet", 32'(seen), 32'h0);
        issue_if(32'h200);
        wait_done(1'b0, lat);
        chk("refetch_lat", 32'(lat), 32'd6);
        chk("refetch_data", if_data, 32'h0010_0093);

        // flush during word store is ignored
        @(negedge clk); wc = wr_count; issue_ls(1'b1, 2'd3, 32'h2100, 32'hCAFE_F00D);
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(negedge clk);
        @(negedge clk); flush = 1'b0;
        wait_done(1'b1, lat);
        chk("sw_flush_lat", 32'(lat + 4), 32'd5);
        chk("sw_flush_ram", {ram[18'h2103], ram[18'h2102], ram[18'h2101], ram[18'h2100]}, 32'hCAFE_F00D);
        chk("sw_flush_wcount", 32'(wr_count - wc), 32'd4);

        // IO back-pressure
        @(negedge clk); wc = wr_count; io_buffer_full = 1'b1;
        issue_ls(1'b1, 2'd0, 32'h3_0000, 32'h41);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("io_stall_wr", 32'(mem_wr), 32'h0);
            chk("io_stall_a", mem_a, 32'h3_0000);
        end
        io_buffer_full = 1'b0;
        #1;
        chk("io_resume_wr", 32'(mem_wr), 32'h1);
        chk("io_resume_d", 32'(mem_dout), 32'h41);
        wait_done(1'b1, lat);
        chk("io_done_lat", 32'(lat), 32'd1);
        chk("io_wcount", 32'(wr_count - wc), 32'd1);
        chk("io_ram", 32'(ram[18'h3_0000]), 32'h41);

        // rdy low mid-load
        @(negedge clk); issue_ls(1'b0, 2'd3, 32'h300, 32'h0);
        @(negedge clk);
        @(negedge clk); rdy = 1'b0; wc = wr_count;
        repeat (4) begin
            @(negedge clk);
            chk("rdy_ld_wr", 32'(mem_wr), 32'h0);
            chk("rdy_ld_done", 32'(lsb_done), 32'h0);
        end
        rdy = 1'b1;
        wait_done(1'b1, lat);
        chk("rdy_ld_data", lsb_rdata, 32'h1234_5678);
        chk("rdy_ld_wcount", 32'(wr_count - wc), 32'd0);

        // rdy low mid-store
        @(negedge clk); wc = wr_count; issue_ls(1'b1, 2'd3, 32'h2300, 32'hA1B2_C3D4);
        @(negedge clk);
        @(negedge clk); rdy = 1'b0; #1;
        chk("rdy_st_gate", 32'(mem_wr), 32'h0);
        @(negedge clk);
        @(negedge clk); rdy = 1'b1; #1;
        chk("rdy_st_resume", 32'(mem_wr), 32'h1);
        chk("rdy_st_addr", mem_a, 32'h2301);
        wait_done(1'b1, lat);
        chk("rdy_st_ram", {ram[18'h2303], ram[18'h2302], ram[18'h2301], ram[18'h2300]}, 32'hA1B2_C3D4);
        chk("rdy_st_wcount", 32'(wr_count - wc), 32'd4);

        // async reset mid-store
        @(negedge clk); issue_ls(1'b1, 2'd3, 32'h2200, 32'h1122_3344);
        @(negedge clk);
        @(negedge clk);
        chk("rst_st_active", 32'(mem_wr), 32'h1);
        rst = 1'b0; #1;
        chk("rst_async_wr", 32'(mem_wr), 32'h0);
        chk("rst_async_a", mem_a, 32'h0);
        chk("rst_async_d", 32'(mem_dout), 32'h0);
        lsb_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); issue_if(32'h100);
        wait_done(1'b0, lat);
        chk("post_rst_lat", 32'(lat), 32'd6);
        chk("post_rst_data", if_data, 32'h0000_0513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
